// File: rtl/mem_read_responder_if.sv
// mem_read_responder_if
//   Bundles the line-read request channel (S_R_*) and the backing-memory
//   burst channel (M_*) used by mem_read_responder.
//
//   slave  : responder view (the mem_read_responder itself).
//   master : environment view (request initiator plus backing memory).
//
//   S_R_ADDR / S_R_ADDR_VALID  request byte address and request present
//   S_R_DATA / S_R_DATA_VALID  returned line and its one-cycle valid pulse
//   M_ADDR / M_ADDR_VALID / M_ADDR_READY               burst request handshake
//   M_DATA / M_DATA_VALID / M_DATA_LAST / M_DATA_READY read beat handshake
interface mem_read_responder_if #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int BUFFER_SIZE = 512
);
    logic [ADDR_WIDTH-1:0]  S_R_ADDR;
    logic                   S_R_ADDR_VALID;
    logic [BUFFER_SIZE-1:0] S_R_DATA;
    logic                   S_R_DATA_VALID;

    logic [ADDR_WIDTH-1:0]  M_ADDR;
    logic                   M_ADDR_VALID;
    logic                   M_ADDR_READY;
    logic [DATA_WIDTH-1:0]  M_DATA;
    logic                   M_DATA_VALID;
    logic                   M_DATA_LAST;
    logic                   M_DATA_READY;

    modport slave (
        input  S_R_ADDR, S_R_ADDR_VALID,
        output S_R_DATA, S_R_DATA_VALID,
        output M_ADDR, M_ADDR_VALID,
        input  M_ADDR_READY,
        input  M_DATA, M_DATA_VALID, M_DATA_LAST,
        output M_DATA_READY
    );

    modport master (
        output S_R_ADDR, S_R_ADDR_VALID,
        input  S_R_DATA, S_R_DATA_VALID,
        input  M_ADDR, M_ADDR_VALID,
        output M_ADDR_READY,
        output M_DATA, M_DATA_VALID, M_DATA_LAST,
        input  M_DATA_READY
    );
endinterface

// File: rtl/mem_read_responder.sv
// mem_read_responder
//   Serves one line-read request at a time: latches the line-aligned
//   request address, issues it as a single burst on the backing port,
//   assembles BUFFER_SIZE/DATA_WIDTH beats (beat 0 in the LSBs) and returns
//   the line with a one-cycle S_R_DATA_VALID pulse.
//
//   clk           rising-edge clock
//   reset         synchronous active-high reset; aborts any operation
//   bus           mem_read_responder_if.slave (S_R_* request/response,
//                 M_* burst request and read beats)
//   protocol_err  sticky flag: a beat arrived whose LAST flag disagreed with
//                 the beat count
//
//   Every output is either a register or a decode of the state register,
//   so no input reaches an output combinationally.
module mem_read_responder #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int BUFFER_SIZE = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_read_responder_if.slave   bus,
    output logic                  protocol_err
);

    localparam int BEATS      = BUFFER_SIZE / DATA_WIDTH;
    localparam int LINE_BYTES = BUFFER_SIZE / 8;
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [CNT_W-1:0]      LAST_CNT   = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(LINE_BYTES - 1));

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic [ADDR_WIDTH-1:0]  base_addr;
    logic [CNT_W-1:0]       cnt;
    logic [BUFFER_SIZE-1:0] line_buf;
    logic                   err_flag;

    logic                   beat_acc;
    logic                   last_beat;

    assign beat_acc  = (state == DATA) && bus.M_DATA_VALID;
    assign last_beat = (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.S_R_ADDR_VALID) state_next = ADDR;
            ADDR: if (bus.M_ADDR_READY)   state_next = DATA;
            // Completion is decided by the beat count; LAST only feeds
            // the protocol check.
            DATA: if (beat_acc && last_beat) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_addr <= '0;
            cnt       <= '0;
            line_buf  <= '0;
            err_flag  <= 1'b0;
        end else begin
            if ((state == IDLE) && bus.S_R_ADDR_VALID) begin
                base_addr <= bus.S_R_ADDR & ALIGN_MASK;
                cnt       <= '0;
            end
            if (beat_acc) begin
                line_buf[cnt*DATA_WIDTH +: DATA_WIDTH] <= bus.M_DATA;
                cnt <= cnt + 1'b1;
                if (bus.M_DATA_LAST != last_beat) begin
                    err_flag <= 1'b1;
                end
            end
        end
    end

    // The line buffer doubles as the response register: its contents are
    // only meaningful while S_R_DATA_VALID is high, after the fill is done.
    assign bus.M_ADDR         = base_addr;
    assign bus.M_ADDR_VALID   = (state == ADDR);
    assign bus.M_DATA_READY   = (state == DATA);
    assign bus.S_R_DATA       = line_buf;
    assign bus.S_R_DATA_VALID = (state == RESP);
    assign protocol_err       = err_flag;

endmodule

// File: tb/tb_mem_read_responder.sv
module tb_mem_read_responder;

    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int BS    = 512;
    localparam int BEATS = BS / DW;

    logic clk;
    logic reset;
    logic protocol_err;

    mem_read_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUFFER_SIZE(BS)) bus ();

    mem_read_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUFFER_SIZE(BS)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .protocol_err (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int exp_pulses = 0;
    bit err_model = 1'b0;

    logic [BS-1:0] exp_line_q[$];
    int            exp_edge_q[$];

    task automatic chk(input string name, input logic [BS-1:0] act, input logic [BS-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every response pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (bus.S_R_DATA_VALID === 1'b1) begin
            pulses++;
            if (exp_line_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got pulse at edge %0d expected none", edge_cnt);
            end else begin
                logic [BS-1:0] l;
                int            ed;
                l  = exp_line_q.pop_front();
                ed = exp_edge_q.pop_front();
                chk("resp_line", bus.S_R_DATA, l);
                chk("resp_edge", BS'(edge_cnt), BS'(ed));
            end
        end
    end

    // One request plus the backing-memory side of its burst.
    // mode: 0 back-to-back beats, 1 two idle cycles between beats, 2 random gaps.
    // abort_after > 0: reset is asserted once that many beats were accepted.
    task automatic do_fill(input logic [AW-1:0] addr, input int rd, input int mode,
                           input int last_idx, input int abort_after, input bit fixed);
        logic [AW-1:0] base;
        logic [DW-1:0] beats[BEATS];
        logic [BS-1:0] line;
        bit            pat[$];
        int            p, b, addr_cycles, iter, gap;
        bit            seen, beat_prev, mis_prev;

        base = addr & ~AW'(BS / 8 - 1);
        line = '0;
        for (int i = 0; i < BEATS; i++) begin
            beats[i] = fixed ? (64'h1111_0000_0000_0000 + 64'(i)) : {$urandom, $urandom};
            line[i*DW +: DW] = beats[i];
            gap = (mode == 0) ? 0 : (mode == 1) ? 2 : int'($urandom_range(0, 2));
            if (i > 0) for (int g = 0; g < gap; g++) pat.push_back(1'b0);
            pat.push_back(1'b1);
        end

        bus.S_R_ADDR       = addr;
        bus.S_R_ADDR_VALID = 1'b1;
        if (abort_after == 0) begin
            exp_line_q.push_back(line);
            exp_edge_q.push_back(edge_cnt + 2 + rd + pat.size());
            exp_pulses++;
        end

        p = 0; b = 0; addr_cycles = 0; iter = 0;
        seen = 0; beat_prev = 0; mis_prev = 0;
        forever begin
            @(negedge clk);
            iter++;
            if (beat_prev) begin
                err_model = err_model | mis_prev;
                beat_prev = 0;
            end
            chk("protocol_err", BS'(protocol_err), BS'(err_model));
            if (seen) begin
                bus.S_R_ADDR_VALID = 1'b0;
                break;
            end
            if (abort_after > 0 && b == abort_after) begin
                reset              = 1'b1;
                bus.S_R_ADDR_VALID = 1'b0;
                bus.M_DATA_VALID   = 1'b0;
                bus.M_ADDR_READY   = 1'b0;
                break;
            end
            if (iter == 3) bus.S_R_ADDR = ~addr;
            if (bus.M_ADDR_VALID === 1'b1) begin
                addr_cycles++;
                chk("m_addr", BS'(bus.M_ADDR), BS'(base));
                bus.M_ADDR_READY = (addr_cycles > rd);
            end else begin
                bus.M_ADDR_READY = 1'b0;
            end
            if (bus.M_DATA_READY === 1'b1 && b < BEATS) begin
                if (pat[p]) begin
                    bus.M_DATA_VALID = 1'b1;
                    bus.M_DATA       = beats[b];
                    bus.M_DATA_LAST  = (b == last_idx);
                    mis_prev         = ((b == last_idx) != (b == BEATS - 1));
                    beat_prev        = 1;
                    b++;
                end else begin
                    bus.M_DATA_VALID = 1'b0;
                    bus.M_DATA_LAST  = 1'b0;
                end
                p++;
            end else begin
                bus.M_DATA_VALID = 1'b0;
                bus.M_DATA_LAST  = 1'b0;
            end
            if (bus.S_R_DATA_VALID === 1'b1) seen = 1;
            if (iter > 300) begin
                checks++;
                errors++;
                $display("FAIL fill_timeout: got no response after %0d cycles expected one", iter);
                bus.S_R_ADDR_VALID = 1'b0;
                break;
            end
        end

        if (abort_after == 0) begin
            chk("addr_valid_cycles", BS'(addr_cycles), BS'(rd + 1));
        end else begin
            @(negedge clk);
            reset     = 1'b0;
            err_model = 1'b0;
            chk("rst_s_r_data", bus.S_R_DATA, '0);
            chk("rst_m_addr", BS'(bus.M_ADDR), '0);
            chk("rst_ctrl", BS'({bus.S_R_DATA_VALID, bus.M_ADDR_VALID, bus.M_DATA_READY, protocol_err}), '0);
            for (int j = 0; j < 5; j++) begin
                bus.M_DATA_VALID = 1'b1;
                bus.M_DATA       = {$urandom, $urandom};
                bus.M_DATA_LAST  = (j == 4);
                @(negedge clk);
                chk("stray_ctrl", BS'({bus.S_R_DATA_VALID, bus.M_ADDR_VALID, bus.M_DATA_READY, protocol_err}), '0);
            end
            bus.M_DATA_VALID = 1'b0;
            bus.M_DATA_LAST  = 1'b0;
            chk("stray_s_r_data", bus.S_R_DATA, '0);
        end
    endtask

    initial begin
        reset              = 1'b1;
        bus.S_R_ADDR       = '0;
        bus.S_R_ADDR_VALID = 1'b0;
        bus.M_ADDR_READY   = 1'b0;
        bus.M_DATA         = '0;
        bus.M_DATA_VALID   = 1'b0;
        bus.M_DATA_LAST    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_s_r_data", bus.S_R_DATA, '0);
        chk("reset_m_addr", BS'(bus.M_ADDR), '0);
        chk("reset_ctrl", BS'({bus.S_R_DATA_VALID, bus.M_ADDR_VALID, bus.M_DATA_READY, protocol_err}), '0);
        reset = 1'b0;
        @(negedge clk);

        do_fill(64'h1000, 0, 0, 7, 0, 1'b1);
        do_fill(64'h1234, 3, 0, 7, 0, 1'b0);
        do_fill({$urandom, $urandom}, 1, 1, 7, 0, 1'b0);
        do_fill(64'h3000, 0, 0, 5, 0, 1'b0);
        do_fill(64'h3040, 2, 2, 7, 0, 1'b0);
        do_fill(64'h5000, 0, 0, 7, 3, 1'b0);
        do_fill(64'h2000, 0, 0, 7, 0, 1'b0);
        do_fill(64'h40, 0, 0, 7, 0, 1'b0);
        do_fill(64'h80, 0, 0, 7, 0, 1'b0);
        for (int n = 0; n < 4; n++) begin
            do_fill({$urandom, $urandom}, int'($urandom_range(0, 3)), 2, 7, 0, 1'b0);
        end

        repeat (12) @(negedge clk);
        chk("idle_no_request", BS'(bus.M_ADDR_VALID), '0);
        chk("pulse_count", BS'(pulses), BS'(exp_pulses));
        chk("scoreboard_empty", BS'(exp_line_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
